// File: rtl/am386_sdram_bridge.sv
// Am386SX non-pipelined bus cycles (sampled on CLK2) to single-word Avalon-MM SDRAM transfers.
// Optional REQ/RDWAIT watchdog is built when AM386_BRIDGE_TIMEOUT_EN is defined.
module am386_sdram_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [15:0] UNMAPPED_DATA  = 16'hFFFF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cpu_ads_n,
  input  logic        cpu_mio,
  input  logic        cpu_dc,
  input  logic        cpu_wr,
  input  logic [1:0]  cpu_be_n,
  input  logic [22:0] cpu_addr,
  input  logic [15:0] cpu_data_in,
  output logic [15:0] cpu_data_out,
  output logic        cpu_data_oe,
  output logic        cpu_ready_n,
  output logic [21:0] az_addr,
  output logic [1:0]  az_be_n,
  output logic [15:0] az_data,
  output logic        az_rd_n,
  output logic        az_wr_n,
  input  logic [15:0] za_data,
  input  logic        za_valid,
  input  logic        za_waitrequest,
  output logic        busy,
  output logic        timeout_err
);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StWdata  = 3'd1;
  localparam logic [2:0] StReq    = 3'd2;
  localparam logic [2:0] StRdwait = 3'd3;
  localparam logic [2:0] StAck    = 3'd4;

  logic [2:0] state;
  logic       ph;
  logic       cyc_wr;
  logic       mapped;
  logic       tmo_fire;

  // cpu_addr holds A[23:1]; halt/shutdown (M/IO#=1, D/C#=0, W/R#=1) never reaches SDRAM.
  assign mapped = cpu_mio && !cpu_addr[22] && !(!cpu_dc && cpu_wr);
  assign busy   = (state != StIdle);

`ifdef AM386_BRIDGE_TIMEOUT_EN
  localparam int unsigned CntW = ($clog2(TIMEOUT_CYCLES) > 10) ? $clog2(TIMEOUT_CYCLES) : 10;

  logic [CntW-1:0] tmo_cnt;
  logic            tmo_err_q;
  logic            in_wait;

  // Fires only when the normal completion condition is absent on the same edge.
  assign in_wait  = ((state == StReq) && za_waitrequest) || ((state == StRdwait) && !za_valid);
  assign tmo_fire = in_wait && (tmo_cnt == CntW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tmo_cnt   <= '0;
      tmo_err_q <= 1'b0;
    end else begin
      if ((state == StReq) || (state == StRdwait)) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end else begin
        tmo_cnt <= '0;
      end
      if (tmo_fire) begin
        tmo_err_q <= 1'b1;
      end
    end
  end

  assign timeout_err = tmo_err_q;
`else
  assign tmo_fire    = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= StIdle;
      ph           <= 1'b0;
      cyc_wr       <= 1'b0;
      cpu_data_out <= '0;
      cpu_data_oe  <= 1'b0;
      cpu_ready_n  <= 1'b1;
      az_addr      <= '0;
      az_be_n      <= 2'b11;
      az_data      <= '0;
      az_rd_n      <= 1'b1;
      az_wr_n      <= 1'b1;
    end else begin
      ph <= ~ph;
      case (state)
        StIdle: begin
          if (ph && !cpu_ads_n) begin
            az_addr     <= cpu_addr[21:0];
            az_be_n     <= cpu_be_n;
            cyc_wr      <= cpu_wr;
            cpu_data_oe <= !cpu_wr;
            if (!mapped) begin
              state <= StAck;
              if (!cpu_wr) begin
                cpu_data_out <= UNMAPPED_DATA;
              end
            end else if (cpu_wr) begin
              state <= StWdata;
            end else begin
              state   <= StReq;
              az_rd_n <= 1'b0;
            end
          end
        end
        StWdata: begin
          if (ph) begin
            az_data <= cpu_data_in;
            az_wr_n <= 1'b0;
            state   <= StReq;
          end
        end
        StReq: begin
          if (!za_waitrequest) begin
            az_rd_n <= 1'b1;
            az_wr_n <= 1'b1;
            state   <= cyc_wr ? StAck : StRdwait;
          end else if (tmo_fire) begin
            az_rd_n <= 1'b1;
            az_wr_n <= 1'b1;
            state   <= StAck;
            if (!cyc_wr) begin
              cpu_data_out <= UNMAPPED_DATA;
            end
          end
        end
        StRdwait: begin
          if (za_valid) begin
            cpu_data_out <= za_data;
            state        <= StAck;
          end else if (tmo_fire) begin
            cpu_data_out <= UNMAPPED_DATA;
            state        <= StAck;
          end
        end
        StAck: begin
          // READY# spans one full processor clock, starting after a ph==1 edge.
          if (ph) begin
            if (cpu_ready_n) begin
              cpu_ready_n <= 1'b0;
            end else begin
              cpu_ready_n <= 1'b1;
              cpu_data_oe <= 1'b0;
              state       <= StIdle;
            end
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_am386_sdram_bridge.sv
// Self-checking bench for am386_sdram_bridge: directed plan cases plus randomized bus cycles.
module tb_am386_sdram_bridge;

`ifdef AM386_BRIDGE_TIMEOUT_EN
  localparam int unsigned Tmo = 16;
`else
  localparam int unsigned Tmo = 1024;
`endif
  localparam logic [15:0] Unmapped = 16'hFFFF;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cpu_ads_n;
  logic        cpu_mio;
  logic        cpu_dc;
  logic        cpu_wr;
  logic [1:0]  cpu_be_n;
  logic [22:0] cpu_addr;
  logic [15:0] cpu_data_in;
  logic [15:0] cpu_data_out;
  logic        cpu_data_oe;
  logic        cpu_ready_n;
  logic [21:0] az_addr;
  logic [1:0]  az_be_n;
  logic [15:0] az_data;
  logic        az_rd_n;
  logic        az_wr_n;
  logic [15:0] za_data;
  logic        za_valid;
  logic        za_waitrequest;
  logic        busy;
  logic        timeout_err;

  int   tests = 0;
  int   fails = 0;
  logic tb_ph;
  bit   bad;

  logic [23:0] r_a;
  logic [1:0]  r_be;
  logic        r_mio, r_dc, r_wr;
  int          r_wait, r_lat;
  bit          r_extra;

  am386_sdram_bridge #(
    .TIMEOUT_CYCLES(Tmo),
    .UNMAPPED_DATA (Unmapped)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .cpu_ads_n     (cpu_ads_n),
    .cpu_mio       (cpu_mio),
    .cpu_dc        (cpu_dc),
    .cpu_wr        (cpu_wr),
    .cpu_be_n      (cpu_be_n),
    .cpu_addr      (cpu_addr),
    .cpu_data_in   (cpu_data_in),
    .cpu_data_out  (cpu_data_out),
    .cpu_data_oe   (cpu_data_oe),
    .cpu_ready_n   (cpu_ready_n),
    .az_addr       (az_addr),
    .az_be_n       (az_be_n),
    .az_data       (az_data),
    .az_rd_n       (az_rd_n),
    .az_wr_n       (az_wr_n),
    .za_data       (za_data),
    .za_valid      (za_valid),
    .za_waitrequest(za_waitrequest),
    .busy          (busy),
    .timeout_err   (timeout_err)
  );

  always #5 clk = ~clk;

  // Phase as the CPU sees it: 0 after reset, toggling on every CLK2 edge.
  always_ff @(posedge clk) tb_ph <= reset_n ? ~tb_ph : 1'b0;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, required finish within 20000 cycles");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_ready_n"}, cpu_ready_n, 1);
    chk({tag, "_oe"}, cpu_data_oe, 0);
    chk({tag, "_data_out"}, cpu_data_out, 0);
    chk({tag, "_rd_n"}, az_rd_n, 1);
    chk({tag, "_wr_n"}, az_wr_n, 1);
    chk({tag, "_az_addr"}, az_addr, 0);
    chk({tag, "_az_be_n"}, az_be_n, 2'b11);
    chk({tag, "_az_data"}, az_data, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_tmo_err"}, timeout_err, 0);
  endtask

  // Returns just after the ph==1 edge that samples ADS# low.
  task automatic issue_ads(input logic [23:0] a, input logic [1:0] be, input logic mio,
                           input logic dc, input logic wr);
    @(negedge clk);
    while (tb_ph !== 1'b1) @(negedge clk);
    cpu_ads_n   = 1'b0;
    cpu_addr    = a[23:1];
    cpu_be_n    = be;
    cpu_mio     = mio;
    cpu_dc      = dc;
    cpu_wr      = wr;
    cpu_data_in = 16'($urandom);
    @(posedge clk);
  endtask

  task automatic bus_cycle(input string tag, input logic [23:0] a, input logic [1:0] be,
                           input logic mio, input logic dc, input logic wr,
                           input logic [15:0] wdata, input logic [15:0] rdata,
                           input int wait_n, input int lat, input bit extra_ads,
                           input bit no_valid);
    bit          mapped, rdy_ph, stable_bad, data_bad, oe_bad, both_bad, done;
    int          v, r, fs, nrd, nwr, nreq, m, rdy_first, rdy_cnt;
    logic [15:0] exp_data;
    mapped     = mio && !a[23] && !(!dc && wr);
    exp_data   = (mapped && !no_valid) ? rdata : Unmapped;
    fs         = -1;
    nrd        = 0;
    nwr        = 0;
    nreq       = 0;
    m          = -1;
    rdy_first  = -1;
    rdy_cnt    = 0;
    rdy_ph     = 1'b1;
    stable_bad = 1'b0;
    data_bad   = 1'b0;
    oe_bad     = 1'b0;
    both_bad   = 1'b0;
    done       = 1'b0;
    za_valid       = 1'b0;
    za_waitrequest = 1'b1;
    issue_ads(a, be, mio, dc, wr);
    for (int s = 0; s < 120 && !done; s++) begin
      @(negedge clk);
      if (!az_rd_n && !az_wr_n) both_bad = 1'b1;
      if (!az_rd_n || !az_wr_n) begin
        if (fs < 0) fs = s;
        if (!az_rd_n) nrd++;
        else nwr++;
        if (az_addr !== a[22:1] || az_be_n !== be || (wr && az_data !== wdata)) stable_bad = 1'b1;
      end
      if (rdy_first >= 0 && cpu_ready_n) begin
        done = 1'b1;
        if (cpu_data_oe !== 1'b0 || busy !== 1'b0) oe_bad = 1'b1;
      end else begin
        if (!cpu_ready_n) begin
          if (rdy_first < 0) begin
            rdy_first = s;
            rdy_ph    = tb_ph;
          end
          rdy_cnt++;
          if (!wr && cpu_data_out !== exp_data) data_bad = 1'b1;
        end
        if (cpu_data_oe !== !wr || busy !== 1'b1) oe_bad = 1'b1;
      end
      // CPU side for the next edge: data only at the WDATA edge, optional stray ADS#.
      cpu_ads_n   = 1'b1;
      cpu_data_in = (s == 1) ? wdata : 16'($urandom);
      if (extra_ads && s == 1) begin
        cpu_ads_n = 1'b0;
        cpu_addr  = ~a[23:1];
        cpu_be_n  = ~be;
        cpu_mio   = 1'b1;
        cpu_dc    = 1'b1;
        cpu_wr    = ~wr;
      end
      // Avalon slave for the next edge.
      if (m >= 0) m++;
      if (!az_rd_n || !az_wr_n) begin
        nreq++;
        za_waitrequest = (nreq <= wait_n);
        if (!az_rd_n && nreq > wait_n) m = 0;
      end else begin
        za_waitrequest = 1'($urandom);
      end
      za_valid = 1'b0;
      za_data  = 16'($urandom);
      if (!no_valid && m == lat) begin
        za_valid = 1'b1;
        za_data  = rdata;
      end else if ((!az_rd_n || (!no_valid && m > lat)) && $urandom_range(0, 1) == 1) begin
        za_valid = 1'b1;
      end
    end
    za_valid       = 1'b0;
    za_waitrequest = 1'b1;
    // Edge (relative to the ADS edge) at which ACK is entered; READY# follows at the next
    // ph==1 edge, and ph==1 edges are the even ones.
    if (!mapped) v = 0;
    else if (wr) v = wait_n + 3;
    else if (no_valid) v = Tmo;
    else v = wait_n + 1 + lat;
    r = v + ((v % 2 == 0) ? 2 : 1);
    chk({tag, "_done"}, done, 1);
    chk({tag, "_strobe_first"}, fs, !mapped ? -1 : (wr ? 2 : 0));
    chk({tag, "_rd_low_cycles"}, nrd, (mapped && !wr) ? wait_n + 1 : 0);
    chk({tag, "_wr_low_cycles"}, nwr, (mapped && wr) ? wait_n + 1 : 0);
    chk({tag, "_both_strobes"}, both_bad, 0);
    chk({tag, "_req_stable"}, stable_bad, 0);
    chk({tag, "_ready_start"}, rdy_first, r);
    chk({tag, "_ready_width"}, rdy_cnt, 2);
    chk({tag, "_ready_ph"}, rdy_ph, 0);
    chk({tag, "_read_data"}, data_bad, 0);
    chk({tag, "_oe_busy"}, oe_bad, 0);
  endtask

  initial begin
    reset_n        = 1'b0;
    cpu_ads_n      = 1'b1;
    cpu_mio        = 1'b0;
    cpu_dc         = 1'b0;
    cpu_wr         = 1'b0;
    cpu_be_n       = 2'b11;
    cpu_addr       = '0;
    cpu_data_in    = '0;
    za_data        = '0;
    za_valid       = 1'b0;
    za_waitrequest = 1'b1;
    repeat (3) @(negedge clk);
    check_reset("init");
    reset_n = 1'b1;

    bus_cycle("rd_plan", 24'h000100, 2'b00, 1, 1, 0, 16'h0000, 16'h1234, 0, 2, 0, 0);
    bus_cycle("wr_plan", 24'h000202, 2'b10, 1, 1, 1, 16'hA55A, 16'h0000, 3, 1, 0, 0);
    bus_cycle("io_rd", 24'h000080, 2'b00, 0, 1, 0, 16'h0000, 16'h0000, 0, 1, 0, 0);
    bus_cycle("io_wr", 24'h000080, 2'b01, 0, 1, 1, 16'h1111, 16'h0000, 0, 1, 0, 0);
    bus_cycle("halt", 24'h000002, 2'b10, 1, 0, 1, 16'h2222, 16'h0000, 0, 1, 0, 0);
    bus_cycle("hi_rd", 24'h800100, 2'b00, 1, 1, 0, 16'h0000, 16'h3333, 0, 1, 0, 0);
    bus_cycle("busy_ads_rd", 24'h3FFFFE, 2'b01, 1, 1, 0, 16'h0000, 16'hC3C3, 2, 3, 1, 0);
    bus_cycle("busy_ads_wr", 24'h123456, 2'b00, 1, 1, 1, 16'h5AA5, 16'h0000, 1, 1, 1, 0);

    // ADS# sampled on a ph==0 edge must not start a cycle.
    @(negedge clk);
    while (tb_ph !== 1'b0) @(negedge clk);
    cpu_ads_n = 1'b0;
    cpu_addr  = 23'h000080;
    cpu_mio   = 1'b1;
    cpu_dc    = 1'b1;
    cpu_wr    = 1'b0;
    bad       = 1'b0;
    for (int s = 0; s < 8; s++) begin
      @(negedge clk);
      cpu_ads_n = 1'b1;
      if (busy !== 1'b0 || az_rd_n !== 1'b1 || cpu_ready_n !== 1'b1) bad = 1'b1;
    end
    chk("ph0_ads_ignored", bad, 0);

    for (int i = 0; i < 20; i++) begin
      r_a     = {($urandom_range(0, 3) == 0), 23'($urandom)};
      r_a[0]  = 1'b0;
      r_be    = 2'($urandom);
      r_mio   = ($urandom_range(0, 4) != 0);
      r_dc    = ($urandom_range(0, 3) != 0);
      r_wr    = 1'($urandom);
      r_wait  = $urandom_range(0, 4);
      r_lat   = $urandom_range(1, 4);
      r_extra = 1'($urandom);
      bus_cycle("rnd", r_a, r_be, r_mio, r_dc, r_wr, 16'($urandom), 16'($urandom),
                r_wait, r_lat, r_extra, 0);
    end

`ifdef AM386_BRIDGE_TIMEOUT_EN
    bus_cycle("tmo_rd", 24'h000400, 2'b00, 1, 1, 0, 16'h0000, 16'h5A5A, 0, 1, 0, 1);
    chk("tmo_err_set", timeout_err, 1);
    bus_cycle("after_tmo", 24'h000402, 2'b01, 1, 1, 0, 16'h0000, 16'h0F0F, 1, 2, 0, 0);
    chk("tmo_err_sticky", timeout_err, 1);
`else
    // Without the watchdog a read whose data never arrives simply waits.
    issue_ads(24'h000400, 2'b00, 1, 1, 0);
    @(negedge clk);
    cpu_ads_n      = 1'b1;
    za_waitrequest = 1'b0;
    za_valid       = 1'b0;
    bad            = 1'b0;
    for (int s = 0; s < 60; s++) begin
      @(negedge clk);
      if (cpu_ready_n !== 1'b1 || busy !== 1'b1 || timeout_err !== 1'b0) bad = 1'b1;
    end
    chk("no_tmo_wait", bad, 0);
    reset_n = 1'b0;
    @(negedge clk);
    check_reset("rst_rdwait");
    reset_n        = 1'b1;
    za_waitrequest = 1'b1;
`endif

    // Reset while a read strobe is outstanding, then a late response must be ignored.
    za_waitrequest = 1'b1;
    za_valid       = 1'b0;
    issue_ads(24'h000100, 2'b00, 1, 1, 0);
    @(negedge clk);
    cpu_ads_n = 1'b1;
    chk("req_rd_low", az_rd_n, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    check_reset("mid_req");
    reset_n  = 1'b1;
    za_valid = 1'b1;
    za_data  = 16'hBEEF;
    bad      = 1'b0;
    for (int s = 0; s < 12; s++) begin
      @(negedge clk);
      if (s == 2) za_valid = 1'b0;
      if (cpu_ready_n !== 1'b1 || busy !== 1'b0 || cpu_data_oe !== 1'b0) bad = 1'b1;
    end
    za_valid = 1'b0;
    chk("stray_valid_ignored", bad, 0);
    bus_cycle("recover_rd", 24'h000100, 2'b00, 1, 1, 0, 16'h0000, 16'h7E57, 0, 2, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
